// File: rtl/lmfe_pixel_feeder.sv
// Streams one raster frame from image memory to the LMFE core.
// An output register plus a 2-entry prefetch FIFO absorbs LMFE back-pressure.
module lmfe_pixel_feeder #(
  parameter int unsigned N_PIX = 16384,
  parameter int unsigned AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          img_rd,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_q,
  input  logic          busy,
  output logic          in_en,
  output logic [7:0]    Din,
  output logic          active,
  output logic          done
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_PIX - 1);
  localparam logic [CW-1:0] LAST_PIX  = CW'(N_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rd_q, rd_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                pend_q, pend_d;
  logic                out_v_q, out_v_d;
  logic [DW-1:0]       out_q, out_d;
  logic [1:0][DW-1:0]  fifo_q, fifo_d;
  logic [1:0]          f_cnt_q, f_cnt_d;
  logic [CW-1:0]       dcnt_q, dcnt_d;
  logic                done_q, done_d;
  logic                active_q, active_d;

  logic                accept;
  logic                take_img;
  logic [2:0]          commit_sum;
  logic                room;

  // Datapath (output register, FIFO, counters) and FSM next-state.
  always_comb begin
    state_d  = state_q;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    pend_d   = rd_q;
    out_v_d  = out_v_q;
    out_d    = out_q;
    fifo_d   = fifo_q;
    f_cnt_d  = f_cnt_q;
    dcnt_d   = dcnt_q;
    done_d   = 1'b0;
    take_img = pend_q;

    accept = out_v_q & ~busy;

    // Refill the output register from the FIFO first, else straight from memory.
    if (!out_v_q || accept) begin
      if (f_cnt_q != 2'd0) begin
        out_v_d   = 1'b1;
        out_d     = fifo_q[0];
        fifo_d[0] = fifo_q[1];
        f_cnt_d   = f_cnt_q - 2'd1;
      end else if (pend_q) begin
        out_v_d  = 1'b1;
        out_d    = img_q;
        take_img = 1'b0;
      end else begin
        out_v_d = 1'b0;
        out_d   = '0;
      end
    end

    if (take_img) begin
      fifo_d[f_cnt_d[0]] = img_q;
      f_cnt_d            = f_cnt_d + 2'd1;
    end

    dcnt_d = dcnt_q + CW'(accept);

    if (rd_q && (addr_q != LAST_ADDR)) begin
      addr_d = addr_q + AW'(1);
    end

    // A new read must still fit in the FIFO if LMFE stalls from now on.
    commit_sum = 3'(f_cnt_d) + 3'(pend_d);
    room       = (commit_sum < 3'd2);

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          state_d = S_RUN;
          addr_d  = '0;
          dcnt_d  = '0;
          rd_d    = 1'b1;
        end
      end
      S_RUN: begin
        if (rd_q && (addr_q == LAST_ADDR)) begin
          state_d = S_DRAIN;
        end else begin
          rd_d = room;
        end
      end
      S_DRAIN: begin
        if (accept && (dcnt_q == LAST_PIX)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
      fifo_q   <= '0;
      f_cnt_q  <= '0;
      dcnt_q   <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      out_v_q  <= out_v_d;
      out_q    <= out_d;
      fifo_q   <= fifo_d;
      f_cnt_q  <= f_cnt_d;
      dcnt_q   <= dcnt_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  assign img_rd   = rd_q;
  assign img_addr = addr_q;
  assign in_en    = out_v_q;
  assign Din      = out_q;
  assign done     = done_q;
  assign active   = active_q;

endmodule

// File: tb/tb_lmfe_pixel_feeder.sv
// Bench for lmfe_pixel_feeder: cycle table on a 4-pixel instance, scoreboarded
// full-frame runs (stall, restart attempt, mid-frame reset) on a 16384-pixel instance.
module tb_lmfe_pixel_feeder;

  localparam int unsigned NB  = 16384;
  localparam int unsigned AWB = 14;
  localparam int unsigned NS  = 4;
  localparam int unsigned AWS = 3;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           b_reset, b_start, b_busy, b_img_rd, b_in_en, b_active, b_done;
  logic [AWB-1:0] b_img_addr;
  logic [7:0]     b_img_q, b_din;

  logic           s_reset, s_start, s_busy, s_img_rd, s_in_en, s_active, s_done;
  logic [AWS-1:0] s_img_addr;
  logic [7:0]     s_img_q, s_din;

  lmfe_pixel_feeder #(.N_PIX(NB), .AW(AWB)) u_big (
    .clk(clk), .reset(b_reset), .start(b_start), .img_rd(b_img_rd),
    .img_addr(b_img_addr), .img_q(b_img_q), .busy(b_busy), .in_en(b_in_en),
    .Din(b_din), .active(b_active), .done(b_done)
  );

  lmfe_pixel_feeder #(.N_PIX(NS), .AW(AWS)) u_small (
    .clk(clk), .reset(s_reset), .start(s_start), .img_rd(s_img_rd),
    .img_addr(s_img_addr), .img_q(s_img_q), .busy(s_busy), .in_en(s_in_en),
    .Din(s_din), .active(s_active), .done(s_done)
  );

  function automatic logic [7:0] pix(input int a);
    return 8'((a * 37) + ((a / 256) * 11) + 5);
  endfunction

  function automatic logic [7:0] spix(input int a);
    case (a)
      0: return 8'd11;
      1: return 8'd22;
      2: return 8'd33;
      3: return 8'd44;
      default: return 8'hEE;
    endcase
  endfunction

  // Image memories: data one cycle after the read, junk otherwise.
  always @(posedge clk) b_img_q <= b_img_rd ? pix(int'(b_img_addr)) : 8'($urandom);
  always @(posedge clk) s_img_q <= s_img_rd ? spix(int'(s_img_addr)) : 8'($urandom);

  int n_cmp;
  int n_fail;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the big instance: pixel order, read order, look-ahead, done pulse.
  bit mon_en, contig, last_prev;
  int acc_m, rd_m, frames, frame_len;

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_in_en) chk(b_din == pix(acc_m), "din_order", int'(b_din), int'(pix(acc_m)));
      else         chk(b_din == 8'd0, "din_idle", int'(b_din), 0);
      chk(b_done == last_prev, "done_pulse", int'(b_done), int'(last_prev));
      if (last_prev) chk(!b_active, "active_after_done", int'(b_active), 0);
      if (b_img_rd) begin
        chk(int'(b_img_addr) == rd_m, "rd_addr", int'(b_img_addr), rd_m);
        rd_m++;
        chk(rd_m - acc_m <= 3, "reads_ahead", rd_m - acc_m, 3);
      end
      if (contig && acc_m > 0 && acc_m < NB) chk(b_in_en, "contiguous", int'(b_in_en), 1);
      if (b_reset) begin
        acc_m = 0; rd_m = 0; last_prev = 1'b0;
      end else begin
        last_prev = b_in_en && !b_busy && (acc_m == NB - 1);
        if (b_in_en && !b_busy) acc_m++;
        if (b_done) begin
          chk(rd_m == NB, "reads_total", rd_m, NB);
          frame_len = acc_m;
          frames++;
          acc_m = 0;
          rd_m  = 0;
        end
      end
    end
  end

  typedef struct {
    bit             rst, st, bz;
    bit             en;
    logic [7:0]     din;
    bit             rd;
    logic [AWS-1:0] addr;
    bit             act, dn;
  } vec_t;

  function automatic vec_t mk(bit rst, bit st, bit bz, bit en, int din, bit rd, int addr,
                              bit act, bit dn);
    vec_t v;
    v.rst = rst; v.st = st; v.bz = bz; v.en = en; v.din = 8'(din);
    v.rd = rd; v.addr = AWS'(addr); v.act = act; v.dn = dn;
    return v;
  endfunction

  vec_t tbl[22];

  task automatic pulse_big_start();
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
  endtask

  task automatic wait_big_done(input string name, input int limit);
    int n;
    n = 0;
    while (!b_done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk(b_done, name, int'(b_done), 1);
  endtask

  initial begin
    int n, f0, hold, cyc, dcount, max_addr;
    bit tog, s500, done_seen;
    logic [7:0] got[$];

    // rst st bz | en din rd addr act dn
    tbl[0]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,  0, 1, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0,  0, 1, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 11, 1, 2, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 22, 1, 3, 1, 0);
    tbl[5]  = mk(0, 0, 0, 1, 33, 0, 3, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 44, 0, 3, 1, 0);
    tbl[7]  = mk(0, 1, 0, 0,  0, 0, 3, 0, 1);
    tbl[8]  = mk(0, 1, 1, 0,  0, 0, 3, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0,  0, 1, 0, 1, 0);
    tbl[10] = mk(0, 0, 1, 0,  0, 1, 1, 1, 0);
    tbl[11] = mk(0, 0, 1, 1, 11, 1, 2, 1, 0);
    tbl[12] = mk(0, 0, 1, 1, 11, 0, 3, 1, 0);
    tbl[13] = mk(0, 0, 0, 1, 11, 0, 3, 1, 0);
    tbl[14] = mk(0, 0, 0, 1, 22, 1, 3, 1, 0);
    tbl[15] = mk(0, 0, 0, 1, 33, 0, 3, 1, 0);
    tbl[16] = mk(0, 0, 0, 1, 44, 0, 3, 1, 0);
    tbl[17] = mk(0, 0, 0, 0,  0, 0, 3, 0, 1);
    tbl[18] = mk(0, 1, 0, 0,  0, 0, 3, 0, 0);
    tbl[19] = mk(1, 0, 0, 0,  0, 1, 0, 1, 0);
    tbl[20] = mk(1, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0);

    n_cmp = 0; n_fail = 0; mon_en = 1'b0; contig = 1'b0;
    acc_m = 0; rd_m = 0; frames = 0; frame_len = 0; last_prev = 1'b0;
    b_reset = 1'b1; b_start = 1'b0; b_busy = 1'b0;
    s_reset = 1'b1; s_start = 1'b0; s_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 b_reset = 1'b0; s_reset = 1'b0;

    @(negedge clk);
    chk(!b_in_en,          "rst_in_en",  int'(b_in_en),    0);
    chk(b_din == 8'd0,     "rst_din",    int'(b_din),      0);
    chk(!b_img_rd,         "rst_img_rd", int'(b_img_rd),   0);
    chk(b_img_addr == '0,  "rst_addr",   int'(b_img_addr), 0);
    chk(!b_active,         "rst_active", int'(b_active),   0);
    chk(!b_done,           "rst_done",   int'(b_done),     0);
    mon_en = 1'b1;

    // Cycle-exact table on the 4-pixel instance.
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      s_reset = tbl[i].rst; s_start = tbl[i].st; s_busy = tbl[i].bz;
      @(negedge clk);
      chk(s_in_en == tbl[i].en,      $sformatf("tbl%0d_in_en", i),  int'(s_in_en),    int'(tbl[i].en));
      chk(s_din == tbl[i].din,       $sformatf("tbl%0d_din", i),    int'(s_din),      int'(tbl[i].din));
      chk(s_img_rd == tbl[i].rd,     $sformatf("tbl%0d_img_rd", i), int'(s_img_rd),   int'(tbl[i].rd));
      chk(s_img_addr == tbl[i].addr, $sformatf("tbl%0d_addr", i),   int'(s_img_addr), int'(tbl[i].addr));
      chk(s_active == tbl[i].act,    $sformatf("tbl%0d_active", i), int'(s_active),   int'(tbl[i].act));
      chk(s_done == tbl[i].dn,       $sformatf("tbl%0d_done", i),   int'(s_done),     int'(tbl[i].dn));
    end

    // 4-pixel frame under random busy.
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    dcount = 0; max_addr = 0;
    for (int c = 0; c < 100; c++) begin
      s_busy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_in_en && !s_busy) got.push_back(s_din);
      if (s_done) dcount++;
      if (int'(s_img_addr) > max_addr) max_addr = int'(s_img_addr);
      @(posedge clk); #1;
    end
    s_busy = 1'b0;
    chk(got.size() == NS, "small_count", got.size(), NS);
    for (int k = 0; k < NS; k++) begin
      if (k < got.size()) chk(got[k] == spix(k), $sformatf("small_pix%0d", k), int'(got[k]), int'(spix(k)));
    end
    chk(dcount == 1, "small_done_once", dcount, 1);
    chk(max_addr <= NS - 1, "small_addr_max", max_addr, NS - 1);

    // Frame with busy low: latency, contiguous delivery, done timing.
    contig = 1'b1; b_busy = 1'b0; f0 = frames;
    pulse_big_start();
    n = 1;
    while (!b_in_en && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n == 3, "first_in_en_latency", n, 3);
    wait_big_done("frameA_done", NB + 20);
    repeat (2) @(posedge clk);
    #1;
    contig = 1'b0;
    chk(frames == f0 + 1, "frameA_count", frames - f0, 1);
    chk(frame_len == NB, "frameA_len", frame_len, NB);

    // Alternating busy, 50-cycle stall at pixel 100, ignored start at pixel 500.
    f0 = frames;
    pulse_big_start();
    cyc = 0; hold = 0; s500 = 1'b0; tog = 1'b0; done_seen = 1'b0;
    while (!done_seen && cyc < 40000) begin
      b_start = 1'b0;
      if (b_in_en && acc_m == 100 && hold < 50) begin
        b_busy = 1'b1;
        hold++;
      end else begin
        tog    = ~tog;
        b_busy = tog;
      end
      if (acc_m == 500 && !s500) begin
        b_start = 1'b1;
        s500    = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (b_done) done_seen = 1'b1;
    end
    b_busy = 1'b0; b_start = 1'b0;
    chk(done_seen, "frameB_done", int'(done_seen), 1);
    chk(hold == 50, "frameB_stall_len", hold, 50);
    chk(s500, "frameB_restart_tried", int'(s500), 1);
    repeat (2) @(posedge clk);
    #1;
    chk(frames == f0 + 1, "frameB_count", frames - f0, 1);
    chk(frame_len == NB, "frameB_len", frame_len, NB);

    // Reset at pixel 8000, then a fresh frame from address 0.
    pulse_big_start();
    n = 0;
    while (acc_m < 8000 && n < 9000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(acc_m == 8000, "frameC_reach_8000", acc_m, 8000);
    b_reset = 1'b1;
    @(posedge clk); #1 b_reset = 1'b0;
    chk(!b_in_en,         "midrst_in_en",  int'(b_in_en),    0);
    chk(b_din == 8'd0,    "midrst_din",    int'(b_din),      0);
    chk(!b_img_rd,        "midrst_img_rd", int'(b_img_rd),   0);
    chk(b_img_addr == '0, "midrst_addr",   int'(b_img_addr), 0);
    chk(!b_active,        "midrst_active", int'(b_active),   0);
    chk(!b_done,          "midrst_done",   int'(b_done),     0);
    repeat (2) @(posedge clk);
    #1;
    f0 = frames;
    pulse_big_start();
    n = 1;
    while (!b_in_en && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n == 3, "restart_latency", n, 3);
    chk(b_din == pix(0), "restart_first_pix", int'(b_din), int'(pix(0)));
    wait_big_done("frameD_done", NB + 20);
    repeat (2) @(posedge clk);
    #1;
    chk(frames == f0 + 1, "frameD_count", frames - f0, 1);
    chk(frame_len == NB, "frameD_len", frame_len, NB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
